deserializer_multilane: RTL

Parametrised successor to the team's single-bit deserializer FSM. Assembles 1..LANES serial lanes into words of runtime-selectable length, in LSB-first or MSB-first order, and queues completed words in a DEPTH-entry first-word-fall-through (FWFT) output FIFO. The output uses a valid/ready handshake. Sits between a serial front-end and word-wide filter datapath logic.

---
 rtl/deserializer_multilane.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/deserializer_multilane.sv
// Multi-lane serial-to-parallel word assembler with runtime word length and bit
// order, feeding a first-word-fall-through output FIFO with valid/ready handshake.
module deserializer_multilane #(
  parameter  int LANES = 1,
  parameter  int WIDTH = 32,
  parameter  int DEPTH = 4,
  localparam int BEATS = WIDTH / LANES,
  localparam int BW    = $clog2(BEATS + 1),
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_en,
  input  logic [LANES-1:0] iv_din,
  input  logic             i_din_valid,
  output logic             o_ready,
  input  logic             i_msb_first,
  input  logic [BW-1:0]    iv_beats,
  output logic [WIDTH-1:0] ov_dout,
  output logic             o_dout_valid,
  input  logic             i_ready,
  output logic [CW-1:0]    ov_count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  state_t           state_r, state_nxt_s;
  logic [BW-1:0]    cnt_r, cnt_nxt_s;
  logic [BW-1:0]    nb_r, nb_nxt_s;
  logic             msb_r, msb_nxt_s;
  logic [WIDTH-1:0] word_r, word_nxt_s;

  logic [BW-1:0]    nb_eff_s, cur_nb_s, cur_k_s, slot_s;
  logic             cur_msb_s;
  logic [WIDTH-1:0] word_base_s, word_asm_s;
  logic             beat_acc_s, last_s, push_s, pop_s;

  logic             run_r;
  logic [PW-1:0]    wr_ptr_r, rd_ptr_r;
  logic [CW-1:0]    count_r;
  logic [WIDTH-1:0] mem_r [DEPTH];

  function automatic logic [BW-1:0] clamp_beats(input logic [BW-1:0] b);
    if ((b == {BW{1'b0}}) || (b > BW'(BEATS))) begin
      return BW'(BEATS);
    end else begin
      return b;
    end
  endfunction

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    if (p == PW'(DEPTH - 1)) begin
      return {PW{1'b0}};
    end else begin
      return p + PW'(1);
    end
  endfunction

  // run_r keeps o_ready low from reset until the first clock after release
  assign o_ready      = i_en && run_r && (count_r != CW'(DEPTH));
  assign o_dout_valid = (count_r != {CW{1'b0}});
  assign ov_dout      = o_dout_valid ? mem_r[rd_ptr_r] : {WIDTH{1'b0}};
  assign ov_count     = count_r;
  assign beat_acc_s   = i_din_valid && o_ready;
  assign pop_s        = o_dout_valid && i_ready;

  // Beat placement: MSB-first beat k lands in lane slot N_b-1-k, LSB-first in slot k
  always_comb begin
    nb_eff_s = clamp_beats(iv_beats);
    if (state_r == ST_IDLE) begin
      cur_nb_s    = nb_eff_s;
      cur_msb_s   = i_msb_first;
      cur_k_s     = {BW{1'b0}};
      word_base_s = {WIDTH{1'b0}};
    end else begin
      cur_nb_s    = nb_r;
      cur_msb_s   = msb_r;
      cur_k_s     = cnt_r;
      word_base_s = word_r;
    end
    slot_s = cur_msb_s ? (cur_nb_s - cur_k_s - BW'(1)) : cur_k_s;
    word_asm_s = {WIDTH{1'b0}};
    for (int s = 0; s < BEATS; s++) begin
      word_asm_s[s*LANES +: LANES] = (slot_s == BW'(s)) ? iv_din : word_base_s[s*LANES +: LANES];
    end
    last_s = ((cur_k_s + BW'(1)) == cur_nb_s);
  end

  // Next-state and word-completion decision
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    nb_nxt_s    = nb_r;
    msb_nxt_s   = msb_r;
    word_nxt_s  = word_r;
    push_s      = 1'b0;
    if (beat_acc_s) begin
      nb_nxt_s  = cur_nb_s;
      msb_nxt_s = cur_msb_s;
      if (last_s) begin
        push_s      = 1'b1;
        state_nxt_s = ST_IDLE;
        cnt_nxt_s   = {BW{1'b0}};
        word_nxt_s  = {WIDTH{1'b0}};
      end else begin
        state_nxt_s = ST_SHIFT;
        cnt_nxt_s   = cur_k_s + BW'(1);
        word_nxt_s  = word_asm_s;
      end
    end else begin
      push_s = 1'b0;
    end
  end

  // Assembler state registers
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_r <= ST_IDLE;
      cnt_r   <= {BW{1'b0}};
      nb_r    <= BW'(BEATS);
      msb_r   <= 1'b0;
      word_r  <= {WIDTH{1'b0}};
      run_r   <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
      nb_r    <= nb_nxt_s;
      msb_r   <= msb_nxt_s;
      word_r  <= word_nxt_s;
      run_r   <= 1'b1;
    end
  end

  // FIFO pointers and occupancy; a push into an empty FIFO shows up next cycle
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr_r <= {PW{1'b0}};
      rd_ptr_r <= {PW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      if (push_s) begin
        wr_ptr_r <= ptr_inc(wr_ptr_r);
      end else begin
        wr_ptr_r <= wr_ptr_r;
      end
      if (pop_s) begin
        rd_ptr_r <= ptr_inc(rd_ptr_r);
      end else begin
        rd_ptr_r <= rd_ptr_r;
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // FIFO storage; contents are masked by the occupancy count so need no reset
  always_ff @(posedge i_clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= word_asm_s;
    end else begin
      mem_r[wr_ptr_r] <= mem_r[wr_ptr_r];
    end
  end

endmodule
